// File: rtl/pir_event_logger.sv
// pir_event_logger
// Watches the PIR alarm controller's buzzer/LED outputs and condenses each
// alarm episode into one 8-bit log word {sensor mask, quantised duration}.
// Words go into an 8-deep circular log that overwrites the oldest entry
// when full. Reads come out one cycle after the pop request.
module pir_event_logger (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buzzer,
    input  logic [2:0] LED,
    input  logic       rd_en,
    input  logic       clear,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       empty,
    output logic       full,
    output logic [3:0] count,
    output logic       overflow,
    output logic [7:0] event_cnt
);

    localparam int DUR_W   = 7;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;
    localparam int ENTRY_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Edge detection
    logic buz_q;
    logic armed;
    logic rise;

    // Episode accumulation
    logic [DUR_W-1:0] dur;
    logic [2:0]       acc_mask;
    logic             ld_ep;
    logic             ext_ep;
    logic             commit;

    // Log storage and control
    logic [ENTRY_W-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] wr_word;
    logic               wr_req;
    logic               pop_req;
    logic               mem_we;

    // Saturating increment keeps long episodes pinned at the maximum duration.
    function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] d);
        logic [DUR_W-1:0] d_max;
        d_max = '1;
        return (d == d_max) ? d : d + {{(DUR_W-1){1'b0}}, 1'b1};
    endfunction

    // A rising edge only counts once buzzer has been seen low since reset,
    // so a buzzer that is already high at reset release is not an episode.
    assign rise = buzzer & ~buz_q & armed;

    // Buzzer history and the post-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buz_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            buz_q <= buzzer;
            if (!buzzer) begin
                armed <= 1'b1;
            end
        end
    end

    // Episode FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Episode FSM next-state logic; a rise during COMMIT is deliberately lost.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rise)    state_nxt = S_ACTIVE;
            S_ACTIVE: if (!buzzer) state_nxt = S_COMMIT;
            S_COMMIT:              state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Episode FSM decoded controls.
    always_comb begin
        ld_ep  = 1'b0;
        ext_ep = 1'b0;
        commit = 1'b0;
        case (state)
            S_IDLE:   ld_ep  = rise;
            S_ACTIVE: ext_ep = buzzer;
            S_COMMIT: commit = 1'b1;
            default: ;
        endcase
    end

    // Duration and sensor mask accumulate over the high phase of the episode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur      <= '0;
            acc_mask <= '0;
        end else if (ld_ep) begin
            dur      <= {{(DUR_W-1){1'b0}}, 1'b1};
            acc_mask <= LED;
        end else if (ext_ep) begin
            dur      <= dur_sat_inc(dur);
            acc_mask <= acc_mask | LED;
        end
    end

    // Episode counter; clear leaves it alone because it counts episodes, not log words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt <= '0;
        end else if (commit) begin
            event_cnt <= event_cnt + 8'd1;
        end
    end

    // Duration is quantised to 4-cycle units to fit five bits.
    assign wr_word = {acc_mask, dur[DUR_W-1:2]};
    assign wr_req  = commit;
    assign pop_req = rd_en & ~empty;
    assign mem_we  = wr_req & ~clear;

    assign empty = (count == 4'd0);
    assign full  = (count == 4'd8);

    // Log RAM is never reset or flushed; only pointers and count say what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointer, occupancy, overflow and read-port bookkeeping; clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_req;
            if (pop_req) begin
                rd_data <= mem[rd_ptr];
            end
            if (wr_req) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            // A write into a full log without a pop drops the oldest entry.
            if (pop_req || (wr_req && full)) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            if (wr_req && !pop_req && full) begin
                overflow <= 1'b1;
            end
            if (wr_req && !pop_req && !full) begin
                count <= count + 4'd1;
            end else if (!wr_req && pop_req) begin
                count <= count - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pir_event_logger.sv
// Testbench for pir_event_logger: a fixed vector table, directed episode
// sequences for the log corner cases, and a randomized run, all checked
// against a queue-based behavioural model of the logger.
module tb_pir_event_logger;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       buzzer = 1'b0;
    logic [2:0] LED    = 3'b000;
    logic       rd_en  = 1'b0;
    logic       clear  = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] event_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pir_event_logger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buzzer    (buzzer),
        .LED       (LED),
        .rd_en     (rd_en),
        .clear     (clear),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .event_cnt (event_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: the log is a queue of words, an episode is a run length and OR of masks.
    logic [7:0] m_q[$];
    bit         m_prev;
    bit         m_armed;
    bit         m_in_ep;
    bit         m_commit;
    int         m_len;
    logic [2:0] m_mask;
    logic [7:0] m_evc;
    logic [7:0] m_rd;
    bit         m_valid;
    bit         m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_prev   = 0;
        m_armed  = 0;
        m_in_ep  = 0;
        m_commit = 0;
        m_len    = 0;
        m_mask   = 3'b000;
        m_evc    = 8'd0;
        m_rd     = 8'd0;
        m_valid  = 0;
        m_ovf    = 0;
    endtask

    task automatic model_update();
        bit         rise;
        bit         pop;
        logic [7:0] word;
        logic [7:0] dropped;
        rise = buzzer && !m_prev && m_armed;
        pop  = rd_en && (m_q.size() > 0);
        if (clear) begin
            m_q.delete();
            m_ovf   = 0;
            m_valid = 0;
        end else begin
            m_valid = pop;
            if (pop) m_rd = m_q.pop_front();
            if (m_commit) begin
                word = {m_mask, 5'(m_len / 4)};
                if (m_q.size() == 8) begin
                    dropped = m_q.pop_front();
                    m_ovf   = 1;
                end
                m_q.push_back(word);
            end
        end
        if (m_commit) m_evc = m_evc + 8'd1;
        if (m_commit) begin
            m_commit = 0;
        end else if (m_in_ep) begin
            if (buzzer) begin
                m_len  = (m_len + 1 > 127) ? 127 : m_len + 1;
                m_mask = m_mask | LED;
            end else begin
                m_in_ep  = 0;
                m_commit = 1;
            end
        end else if (rise) begin
            m_in_ep = 1;
            m_len   = 1;
            m_mask  = LED;
        end
        m_prev = buzzer;
        if (!buzzer) m_armed = 1;
    endtask

    task automatic model_check();
        bit ok;
        ok = (rd_valid === m_valid) && (rd_data === m_rd) &&
             (count === 4'(m_q.size())) && (empty === (m_q.size() == 0)) &&
             (full === (m_q.size() == 8)) && (overflow === m_ovf) &&
             (event_cnt === m_evc);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL model t=%0t: got vld=%0b data=%h cnt=%0d empty=%0b full=%0b ovf=%0b evc=%0d, want vld=%0b data=%h cnt=%0d ovf=%0b evc=%0d",
                     $time, rd_valid, rd_data, count, empty, full, overflow, event_cnt,
                     m_valid, m_rd, m_q.size(), m_ovf, m_evc);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic [2:0] l, input logic r, input logic c);
        buzzer = b;
        LED    = l;
        rd_en  = r;
        clear  = c;
    endtask

    // One clock: model advances on the edge, outputs are compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    // Asynchronous reset asserted between edges; outputs are checked before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        model_check();
        chk("rst_count", count, 0);
        chk("rst_evc", event_cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valid", rd_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic episode(input int len, input logic [2:0] m);
        drive(1'b1, m, 1'b0, 1'b0);
        repeat (len) step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        chk({nm, "_vld"}, rd_valid, 1);
        chk({nm, "_data"}, rd_data, exp);
    endtask

    typedef struct {
        logic       buz;
        logic [2:0] led;
        logic       rd;
        logic       clr;
        logic [3:0] cnt;
        logic [7:0] evc;
        logic       vld;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // buz led rd clr | cnt evc vld data
        tbl[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 3'b011, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 3'b100, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd1, 8'd1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd1, 1'b1, 8'hE1};
        tbl[8]  = '{1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd1, 1'b0, 8'hE1};
        tbl[9]  = '{1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0, 8'hE1};
        tbl[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0, 8'hE1};
        tbl[11] = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2, 1'b0, 8'hE1};
        tbl[12] = '{1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd2, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2, 1'b0, 8'h00};

        model_reset();
        do_reset();

        // Table of short episodes, pops and an empty-pop
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].buz, tbl[i].led, tbl[i].rd, tbl[i].clr);
            step();
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_evc", i), event_cnt, tbl[i].evc);
            chk($sformatf("tbl%0d_vld", i), rd_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].dat);
        end

        // 40-cycle episode, single sensor
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        episode(40, 3'b010);
        chk("ep40_count", count, 1);
        chk("ep40_evc", event_cnt, 1);
        pop_expect("ep40", 8'b010_01010);

        // 200-cycle episode, mask grows, duration saturates
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        repeat (50) step();
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        repeat (150) step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        repeat (3) step();
        pop_expect("sat", 8'b101_11111);

        // Nine episodes into an 8-deep log, then drain
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 9; k++) episode(4 * k, 3'(k));
        chk("ovr_count", count, 8);
        chk("ovr_full", full, 1);
        chk("ovr_flag", overflow, 1);
        for (int k = 2; k <= 9; k++) pop_expect($sformatf("ovr_pop%0d", k), {3'(k), 5'(k)});
        chk("ovr_empty", empty, 1);

        // Full log, commit coincides with a pop
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 8; k++) episode(4 * k, 3'(k));
        chk("fullpop_pre_full", full, 1);
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        repeat (36) step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        chk("fullpop_vld", rd_valid, 1);
        chk("fullpop_data", rd_data, 8'h21);
        chk("fullpop_count", count, 8);
        chk("fullpop_ovf", overflow, 0);
        step();

        // Clear coincident with a pop
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 3; k++) episode(8, 3'b100);
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        chk("clr_count", count, 0);
        chk("clr_vld", rd_valid, 0);
        chk("clr_empty", empty, 1);
        chk("clr_evc", event_cnt, 3);

        // Reset in the middle of an episode, buzzer still high at release
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        step();
        episode(8, 3'b001);
        chk("midrst_pre_count", count, 1);
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        repeat (5) step();
        do_reset();
        chk("midrst_data", rd_data, 0);
        repeat (10) step();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        repeat (5) step();
        chk("midrst_post_count", count, 0);
        chk("midrst_post_evc", event_cnt, 0);

        // Randomized traffic against the model
        do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if ($urandom_range(0, 7) == 0) buzzer = ~buzzer;
            LED   = 3'($urandom);
            rd_en = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
